pe_array_ctrl: RTL and testbench
================================

# pe_array_ctrl

Sequencing controller for `pe_array`. It loads filter coefficients into PEs one at a time, then for each output tile it shifts an input window into the B-chain, runs `NUM_DATA` MAC cycles and drains the adder tree. It raises `obuf_write` for each result. It sits between the ibuf read port and the `pe_array` control inputs, and it generates every `pe_array` control strobe.

## Interface
Parameters:
- `ARRAY_M`, 8, output channels (rows)
- `ARRAY_N`, 8, kernels per channel (B-chain depth)
- `NUM_PES`, `ARRAY_M*ARRAY_N`, PE count
- `NUM_DATA`, 16, MAC cycles per tile
- `SIGNED_ADDER_DELAY`, 2, adder enable pipeline depth in `pe_array`
- `TILE_WIDTH`, 16, width of tile counter
- `NUM_PE_WIDTH`, `$clog2(NUM_PES)+1`, filter count width
- `NUM_KERNEL_WIDTH`, `$clog2(ARRAY_N)+1`, kernel count width

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `cfg_num_filter` in NUM_PE_WIDTH: filters to load. 0 = keep the resident filters.
- `cfg_num_kernel` in NUM_KERNEL_WIDTH: forwarded to `pe_num_kernel`.
- `cfg_num_tiles` in TILE_WIDTH: tiles to compute.
- `ibuf_rd_en` out 1: read request to ibuf.
- `ibuf_rd_valid` in 1: ibuf data on `ibuf_read_data` is valid this cycle.
- `pe_acc` in 1: `acc` output of `pe_array`.
- `pe_enable`, `pe_sys_start`, `pe_input_load`, `pe_sum_timestep` out 1 each: `pe_array` controls.
- `pe_filter_addr` out NUM_PES: one-hot Aload select.
- `pe_num_filter` out NUM_PE_WIDTH: latched config.
- `pe_num_kernel` out NUM_KERNEL_WIDTH: latched config.
- `obuf_write` out 1: the `obuf_write_data` of `pe_array` is valid.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- **States:** IDLE, LD_FILT, LD_IN, COMPUTE, DRAIN, DONE.
- **IDLE:**
  - When `start`=1, latch the three cfg values and clear `fcnt`, `bcnt`, `tcnt`.
  - If `cfg_num_tiles`==0, go to DONE.
  - Else if `cfg_num_filter`==0, go to LD_IN.
  - Else go to LD_FILT.
- **LD_FILT:**
  - `ibuf_rd_en`=1.
  - On a cycle with `ibuf_rd_valid`, assert `pe_filter_addr[fcnt]` combinationally in the same cycle, then increment `fcnt`.
  - When the beat with `fcnt`==num_filter-1 is accepted, go to LD_IN.
  - When `ibuf_rd_valid`=0, `pe_filter_addr` is 0 and `fcnt` holds.
- **LD_IN:**
  - `ibuf_rd_en`=1.
  - Each valid beat drives `pe_input_load`=1 in the same cycle and increments `bcnt`.
  - After `ARRAY_N` beats, clear `bcnt` and go to COMPUTE.
- **COMPUTE:**
  - `pe_sys_start`=1 and `pe_enable`=1 for exactly `NUM_DATA` cycles, counted by `bcnt`.
  - `ibuf_rd_en`=0.
  - Then go to DRAIN.
- **DRAIN:**
  - Lasts D = `SIGNED_ADDER_DELAY`+2 cycles. `pe_enable`=1 and `pe_sys_start`=0.
  - `pe_sum_timestep`=1 on the first DRAIN cycle only.
  - `obuf_write` = `pe_acc` while in DRAIN. At most one pulse per tile is expected.
  - At the end of DRAIN, increment `tcnt`. If `tcnt`<num_tiles go to LD_IN, else go to DONE.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- **Config outputs:** `pe_num_filter` and `pe_num_kernel` are registered from the latched config and hold their value until the next accepted `start`.
- **Counter widths:** `fcnt` is NUM_PE_WIDTH, `bcnt` is $clog2(max(ARRAY_N,NUM_DATA))+1, `tcnt` is TILE_WIDTH. Counters do not wrap within a run.

## Timing
- **Reset values:** every output is 0 and the state is IDLE.
  - `reset` at any point, including mid-LD_FILT or mid-COMPUTE, forces IDLE on the next edge.
  - A partially loaded filter set is not recovered after reset.
- **`start` handling:** `start` while `busy` is ignored. `start` and `reset` together: reset wins.
- **Latency with `ibuf_rd_valid` stuck high:**
  - `start` is sampled at cycle 0. LD_FILT occupies cycles 1..F.
  - Each tile takes `ARRAY_N`+`NUM_DATA`+D cycles.
  - `done` is high at cycle 1+F+T·(`ARRAY_N`+`NUM_DATA`+D).
- **ibuf stalls:** stalls stretch only LD_FILT and LD_IN. The COMPUTE and DRAIN lengths are fixed.
- **Stray valid:** `ibuf_rd_valid` while `ibuf_rd_en`=0 is ignored, with no counter change and no strobe.
- **Exclusivity:**
  - `pe_filter_addr` is never non-zero outside LD_FILT.
  - `pe_input_load` is never 1 outside LD_IN.
  - `pe_sys_start` is never 1 outside COMPUTE.

## Test plan
- **Full run, no stalls:** defaults, F=64, T=1, valid always 1.
  - `pe_filter_addr` walks bits 0..63 over cycles 1..64.
  - `pe_input_load` is high for cycles 65..72.
  - `pe_sys_start` is high for cycles 73..88.
  - `pe_sum_timestep` is high at cycle 89.
  - `done` is high at cycle 93.
- **Stalled ibuf:** F=4, T=1, `ibuf_rd_valid` toggling 1,0,1,0…
  - Exactly 4 one-hot addr pulses (bits 0..3), each aligned with a valid beat.
  - Exactly 8 `pe_input_load` pulses.
  - The COMPUTE length stays 16 cycles.
- **Filter reuse, multi-tile:** F=0, T=3.
  - No `pe_filter_addr` activity.
  - Three LD_IN/COMPUTE/DRAIN rounds of 28 cycles each.
  - `done` is high at cycle 85.
  - When `pe_acc` is driven 2 cycles after each sum_timestep, `obuf_write` produces 3 pulses.
- **Degenerate config:** T=0 gives `done` at cycle 1 and `busy` at cycle 1 only. `start` repeated while busy is ignored, so there is no restart and `done` still fires once.
- **Reset mid-COMPUTE:** `reset` pulsed in the 5th COMPUTE cycle.
  - On the next cycle all outputs are 0 and `busy`=0.
  - A fresh `start` then runs a full sequence correctly.

Source files
------------

// File: rtl/pe_array_ctrl.sv
// ---------------------------------------------------------------------------
// pe_array_ctrl
//
// Sequencing controller for pe_array. It loads filter coefficients one PE at
// a time from the ibuf. Then, for every output tile, it shifts an input
// window into the B-chain, runs NUM_DATA MAC cycles and drains the adder
// tree. It raises obuf_write when pe_array reports a finished accumulation.
//
// Ports
//   clk, reset        : single clock, synchronous active-high reset
//   start             : one-cycle run request, only honoured while idle
//   cfg_num_filter    : filters to load (0 = reuse resident filters)
//   cfg_num_kernel    : kernel count, forwarded to pe_num_kernel
//   cfg_num_tiles     : number of output tiles to compute
//   ibuf_rd_en        : read request to ibuf
//   ibuf_rd_valid     : ibuf read data valid this cycle
//   pe_acc            : accumulation-complete flag from pe_array
//   pe_enable, pe_sys_start, pe_input_load, pe_sum_timestep : pe_array strobes
//   pe_filter_addr    : one-hot filter-load select
//   pe_num_filter     : latched filter count
//   pe_num_kernel     : latched kernel count
//   obuf_write        : pe_array result valid
//   busy              : controller is not idle
//   done              : one-cycle completion pulse
// ---------------------------------------------------------------------------
module pe_array_ctrl #(
   parameter int ARRAY_M            = 8,
   parameter int ARRAY_N            = 8,
   parameter int NUM_PES            = ARRAY_M * ARRAY_N,
   parameter int NUM_DATA           = 16,
   parameter int SIGNED_ADDER_DELAY = 2,
   parameter int TILE_WIDTH         = 16,
   parameter int NUM_PE_WIDTH       = $clog2(NUM_PES) + 1,
   parameter int NUM_KERNEL_WIDTH   = $clog2(ARRAY_N) + 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [NUM_PE_WIDTH-1:0]     cfg_num_filter,
   input  logic [NUM_KERNEL_WIDTH-1:0] cfg_num_kernel,
   input  logic [TILE_WIDTH-1:0]       cfg_num_tiles,
   output logic                        ibuf_rd_en,
   input  logic                        ibuf_rd_valid,
   input  logic                        pe_acc,
   output logic                        pe_enable,
   output logic                        pe_sys_start,
   output logic                        pe_input_load,
   output logic                        pe_sum_timestep,
   output logic [NUM_PES-1:0]          pe_filter_addr,
   output logic [NUM_PE_WIDTH-1:0]     pe_num_filter,
   output logic [NUM_KERNEL_WIDTH-1:0] pe_num_kernel,
   output logic                        obuf_write,
   output logic                        busy,
   output logic                        done
);

   // Drain covers the adder-tree pipeline plus the sum and write-back cycles.
   localparam int DRAIN_CYC = SIGNED_ADDER_DELAY + 2;
   localparam int BMAX      = (ARRAY_N > NUM_DATA) ? ARRAY_N : NUM_DATA;
   localparam int BCNT_W    = $clog2(BMAX) + 1;

   localparam logic [NUM_PES-1:0] ADDR_ONE = NUM_PES'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_FILT,
      S_LD_IN,
      S_COMPUTE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                      state_q, state_d;
   logic [NUM_PE_WIDTH-1:0]     fcnt_q, fcnt_d;
   logic [BCNT_W-1:0]           bcnt_q, bcnt_d;
   logic [TILE_WIDTH-1:0]       tcnt_q, tcnt_d;
   logic [NUM_PE_WIDTH-1:0]     filt_q, filt_d;
   logic [NUM_KERNEL_WIDTH-1:0] kern_q, kern_d;
   logic [TILE_WIDTH-1:0]       tiles_q, tiles_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         fcnt_q  <= '0;
         bcnt_q  <= '0;
         tcnt_q  <= '0;
         filt_q  <= '0;
         kern_q  <= '0;
         tiles_q <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         bcnt_q  <= bcnt_d;
         tcnt_q  <= tcnt_d;
         filt_q  <= filt_d;
         kern_q  <= kern_d;
         tiles_q <= tiles_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      fcnt_d          = fcnt_q;
      bcnt_d          = bcnt_q;
      tcnt_d          = tcnt_q;
      filt_d          = filt_q;
      kern_d          = kern_q;
      tiles_d         = tiles_q;
      ibuf_rd_en      = 1'b0;
      pe_enable       = 1'b0;
      pe_sys_start    = 1'b0;
      pe_input_load   = 1'b0;
      pe_sum_timestep = 1'b0;
      pe_filter_addr  = '0;
      obuf_write      = 1'b0;
      done            = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               filt_d  = cfg_num_filter;
               kern_d  = cfg_num_kernel;
               tiles_d = cfg_num_tiles;
               fcnt_d  = '0;
               bcnt_d  = '0;
               tcnt_d  = '0;
               if (cfg_num_tiles == '0)
                  state_d = S_DONE;
               else if (cfg_num_filter == '0)
                  state_d = S_LD_IN;
               else
                  state_d = S_LD_FILT;
            end
         end

         S_LD_FILT: begin
            ibuf_rd_en = 1'b1;
            // The address strobe rides on the same cycle as the ibuf beat.
            if (ibuf_rd_valid) begin
               pe_filter_addr = ADDR_ONE << fcnt_q;
               fcnt_d         = fcnt_q + NUM_PE_WIDTH'(1);
               if (fcnt_q == filt_q - NUM_PE_WIDTH'(1))
                  state_d = S_LD_IN;
            end
         end

         S_LD_IN: begin
            ibuf_rd_en = 1'b1;
            if (ibuf_rd_valid) begin
               pe_input_load = 1'b1;
               if (bcnt_q == BCNT_W'(ARRAY_N - 1)) begin
                  bcnt_d  = '0;
                  state_d = S_COMPUTE;
               end else begin
                  bcnt_d = bcnt_q + BCNT_W'(1);
               end
            end
         end

         S_COMPUTE: begin
            pe_sys_start = 1'b1;
            pe_enable    = 1'b1;
            if (bcnt_q == BCNT_W'(NUM_DATA - 1)) begin
               bcnt_d  = '0;
               state_d = S_DRAIN;
            end else begin
               bcnt_d = bcnt_q + BCNT_W'(1);
            end
         end

         S_DRAIN: begin
            // bcnt is reused as the drain cycle counter.
            pe_enable       = 1'b1;
            pe_sum_timestep = (bcnt_q == '0);
            obuf_write      = pe_acc;
            if (bcnt_q == BCNT_W'(DRAIN_CYC - 1)) begin
               bcnt_d = '0;
               tcnt_d = tcnt_q + TILE_WIDTH'(1);
               if (tcnt_q + TILE_WIDTH'(1) < tiles_q)
                  state_d = S_LD_IN;
               else
                  state_d = S_DONE;
            end else begin
               bcnt_d = bcnt_q + BCNT_W'(1);
            end
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign busy          = (state_q != S_IDLE);
   assign pe_num_filter = filt_q;
   assign pe_num_kernel = kern_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
module tb_pe_array_ctrl;

   localparam int TILE_CYC = 8 + 16 + 4;

   logic        clk;
   logic        reset;
   logic        start;
   logic [6:0]  cfg_num_filter;
   logic [3:0]  cfg_num_kernel;
   logic [15:0] cfg_num_tiles;
   logic        ibuf_rd_en;
   logic        ibuf_rd_valid;
   logic        pe_acc;
   logic        pe_enable;
   logic        pe_sys_start;
   logic        pe_input_load;
   logic        pe_sum_timestep;
   logic [63:0] pe_filter_addr;
   logic [6:0]  pe_num_filter;
   logic [3:0]  pe_num_kernel;
   logic        obuf_write;
   logic        busy;
   logic        done;

   int n_cmp;
   int n_fail;

   pe_array_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .cfg_num_filter  (cfg_num_filter),
      .cfg_num_kernel  (cfg_num_kernel),
      .cfg_num_tiles   (cfg_num_tiles),
      .ibuf_rd_en      (ibuf_rd_en),
      .ibuf_rd_valid   (ibuf_rd_valid),
      .pe_acc          (pe_acc),
      .pe_enable       (pe_enable),
      .pe_sys_start    (pe_sys_start),
      .pe_input_load   (pe_input_load),
      .pe_sum_timestep (pe_sum_timestep),
      .pe_filter_addr  (pe_filter_addr),
      .pe_num_filter   (pe_num_filter),
      .pe_num_kernel   (pe_num_kernel),
      .obuf_write      (obuf_write),
      .busy            (busy),
      .done            (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {rd_en, input_load, sys_start, enable, sum_timestep, obuf_write, done, busy}
   function automatic logic [7:0] ctrl_vec();
      return {ibuf_rd_en, pe_input_load, pe_sys_start, pe_enable,
              pe_sum_timestep, obuf_write, done, busy};
   endfunction

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; cfg_num_filter = 7'd5; cfg_num_kernel = 4'd3;
      cfg_num_tiles = 16'd2; ibuf_rd_valid = 1'b1; pe_acc = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if (ctrl_vec() !== 8'b0) begin
         n_fail++; $display("FAIL reset_ctrl got %b exp %b", ctrl_vec(), 8'b0);
      end
      n_cmp++;
      if ({pe_filter_addr, pe_num_filter, pe_num_kernel} !== '0) begin
         n_fail++; $display("FAIL reset_data got %h/%0d/%0d exp 0", pe_filter_addr, pe_num_filter, pe_num_kernel);
      end
      @(negedge clk);
      reset = 1'b0; start = 1'b0; ibuf_rd_valid = 1'b0; pe_acc = 1'b0;
      @(negedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_start_ignored busy got %b exp 0", busy);
      end
   endtask

   task automatic test_full_run(input int f, input int t);
      int last, k;
      logic in_t;
      logic [7:0]  e_ctrl;
      logic [63:0] e_addr;
      logic [63:0] one64;
      one64 = 64'd1;
      last  = 1 + f + t * TILE_CYC;
      @(negedge clk);
      start = 1'b1; cfg_num_filter = 7'(f); cfg_num_kernel = 4'd8;
      cfg_num_tiles = 16'(t); ibuf_rd_valid = 1'b1; pe_acc = 1'b0;
      for (int c = 1; c <= last + 2; c++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         in_t   = (c > f) && (c < last);
         k      = in_t ? (c - 1 - f) % TILE_CYC : 0;
         e_addr = (c <= f) ? (one64 << (c - 1)) : 64'd0;
         e_ctrl = {((c <= f) || (in_t && k < 8)), (in_t && k < 8),
                   (in_t && k >= 8 && k < 24), (in_t && k >= 8), (in_t && k == 24),
                   1'b0, (c == last), (c <= last)};
         n_cmp++;
         if (pe_filter_addr !== e_addr) begin
            n_fail++; $display("FAIL full_addr f=%0d c=%0d got %h exp %h", f, c, pe_filter_addr, e_addr);
         end
         n_cmp++;
         if (ctrl_vec() !== e_ctrl) begin
            n_fail++; $display("FAIL full_ctrl f=%0d c=%0d got %b exp %b", f, c, ctrl_vec(), e_ctrl);
         end
         n_cmp++;
         if (pe_num_filter !== 7'(f) || pe_num_kernel !== 4'd8) begin
            n_fail++; $display("FAIL full_cfg c=%0d got %0d/%0d exp %0d/8", c, pe_num_filter, pe_num_kernel, f);
         end
      end
   endtask

   task automatic test_stalled_ibuf();
      int n_addr, n_load, n_sys;
      logic [7:0]  e_ctrl;
      logic [63:0] e_addr;
      logic [63:0] one64;
      logic odd;
      one64 = 64'd1; n_addr = 0; n_load = 0; n_sys = 0;
      @(negedge clk);
      start = 1'b1; cfg_num_filter = 7'd4; cfg_num_kernel = 4'd8;
      cfg_num_tiles = 16'd1; ibuf_rd_valid = 1'b0; pe_acc = 1'b0;
      for (int c = 1; c <= 46; c++) begin
         @(negedge clk);
         start = 1'b0;
         odd = (c % 2 == 1);
         ibuf_rd_valid = odd;
         #1;
         e_addr = (odd && c <= 7) ? (one64 << ((c - 1) / 2)) : 64'd0;
         e_ctrl = {(c <= 23), (odd && c >= 9 && c <= 23), (c >= 24 && c <= 39),
                   (c >= 24 && c <= 43), (c == 40), 1'b0, (c == 44), (c <= 44)};
         if (pe_filter_addr != '0) n_addr++;
         if (pe_input_load) n_load++;
         if (pe_sys_start) n_sys++;
         n_cmp++;
         if (pe_filter_addr !== e_addr) begin
            n_fail++; $display("FAIL stall_addr c=%0d got %h exp %h", c, pe_filter_addr, e_addr);
         end
         n_cmp++;
         if (ctrl_vec() !== e_ctrl) begin
            n_fail++; $display("FAIL stall_ctrl c=%0d got %b exp %b", c, ctrl_vec(), e_ctrl);
         end
      end
      ibuf_rd_valid = 1'b0;
      n_cmp++;
      if (n_addr !== 4) begin
         n_fail++; $display("FAIL stall_addr_count got %0d exp 4", n_addr);
      end
      n_cmp++;
      if (n_load !== 8) begin
         n_fail++; $display("FAIL stall_load_count got %0d exp 8", n_load);
      end
      n_cmp++;
      if (n_sys !== 16) begin
         n_fail++; $display("FAIL stall_compute_len got %0d exp 16", n_sys);
      end
   endtask

   task automatic test_multi_tile();
      int k, n_wr;
      logic in_t;
      logic [7:0] e_ctrl;
      n_wr = 0;
      @(negedge clk);
      start = 1'b1; cfg_num_filter = 7'd0; cfg_num_kernel = 4'd5;
      cfg_num_tiles = 16'd3; ibuf_rd_valid = 1'b1; pe_acc = 1'b0;
      for (int c = 1; c <= 88; c++) begin
         @(negedge clk);
         in_t = (c < 85);
         k    = (c - 1) % TILE_CYC;
         // start while busy with a different config must be ignored
         start = (c == 40);
         if (c == 40) begin
            cfg_num_filter = 7'd7; cfg_num_kernel = 4'd2; cfg_num_tiles = 16'd1;
         end
         pe_acc = (in_t && k == 26) || (c == 10) || (c == 86);
         #1;
         e_ctrl = {(in_t && k < 8), (in_t && k < 8), (in_t && k >= 8 && k < 24),
                   (in_t && k >= 8), (in_t && k == 24), (in_t && k == 26),
                   (c == 85), (c <= 85)};
         if (obuf_write) n_wr++;
         n_cmp++;
         if (ctrl_vec() !== e_ctrl) begin
            n_fail++; $display("FAIL multi_ctrl c=%0d got %b exp %b", c, ctrl_vec(), e_ctrl);
         end
         n_cmp++;
         if (pe_filter_addr !== 64'd0 || pe_num_filter !== 7'd0 || pe_num_kernel !== 4'd5) begin
            n_fail++; $display("FAIL multi_cfg c=%0d got %h/%0d/%0d exp 0/0/5", c, pe_filter_addr, pe_num_filter, pe_num_kernel);
         end
      end
      start = 1'b0; pe_acc = 1'b0;
      n_cmp++;
      if (n_wr !== 3) begin
         n_fail++; $display("FAIL multi_obuf_count got %0d exp 3", n_wr);
      end
   endtask

   task automatic test_degenerate();
      int n_done;
      n_done = 0;
      @(negedge clk);
      start = 1'b1; cfg_num_filter = 7'd3; cfg_num_kernel = 4'd1;
      cfg_num_tiles = 16'd0; ibuf_rd_valid = 1'b1; pe_acc = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = (c == 1);
         #1;
         if (done) n_done++;
         n_cmp++;
         if (ctrl_vec() !== {6'b0, (c == 1), (c == 1)}) begin
            n_fail++; $display("FAIL degen_ctrl c=%0d got %b exp %b", c, ctrl_vec(), {6'b0, (c == 1), (c == 1)});
         end
      end
      start = 1'b0;
      n_cmp++;
      if (n_done !== 1) begin
         n_fail++; $display("FAIL degen_done_count got %0d exp 1", n_done);
      end
      n_cmp++;
      if (pe_num_filter !== 7'd3 || pe_num_kernel !== 4'd1) begin
         n_fail++; $display("FAIL degen_cfg got %0d/%0d exp 3/1", pe_num_filter, pe_num_kernel);
      end
   endtask

   task automatic test_reset_mid_compute();
      @(negedge clk);
      start = 1'b1; cfg_num_filter = 7'd2; cfg_num_kernel = 4'd3;
      cfg_num_tiles = 16'd1; ibuf_rd_valid = 1'b1; pe_acc = 1'b1;
      // LD_FILT 1..2, LD_IN 3..10, COMPUTE from 11; 5th compute cycle is 15
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
      end
      n_cmp++;
      if (pe_sys_start !== 1'b1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL rst_pre sys_start/busy got %b%b exp 11", pe_sys_start, busy);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_cmp++;
      if (ctrl_vec() !== 8'b0) begin
         n_fail++; $display("FAIL rst_mid_ctrl got %b exp %b", ctrl_vec(), 8'b0);
      end
      n_cmp++;
      if ({pe_filter_addr, pe_num_filter, pe_num_kernel} !== '0) begin
         n_fail++; $display("FAIL rst_mid_data got %h/%0d/%0d exp 0", pe_filter_addr, pe_num_filter, pe_num_kernel);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_idle busy got %b exp 0", busy);
      end
      pe_acc = 1'b0;
      test_full_run(2, 2);
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      reset = 1'b1; start = 1'b0; cfg_num_filter = '0; cfg_num_kernel = '0;
      cfg_num_tiles = '0; ibuf_rd_valid = 1'b0; pe_acc = 1'b0;
      test_reset();
      test_full_run(64, 1);
      test_stalled_ibuf();
      test_multi_tile();
      test_degenerate();
      test_reset_mid_compute();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
